// File: rtl/etc_sched_pkg.sv
// Shared types and panel defaults for the ETC2 band scheduler.
// Optional statistics counters are enabled with ETC_BAND_SCHED_STATS_EN.
package etc_sched_pkg;

  localparam int unsigned H_BLOCKS_DEF = 120;  // 480 px / 4
  localparam int unsigned V_BLOCKS_DEF = 68;   // 272 px / 4

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } sched_state_e;

endpackage

// File: rtl/etc_band_tracker.sv
// Display-side band bookkeeping: line counter, read bank, per-bank ready bits, underrun.
// ETC_BAND_SCHED_STATS_EN adds a saturating underrun event counter.
module etc_band_tracker (
  input  logic       sclk,
  input  logic       srst,
  input  logic       i_init,
  input  logic       i_set,
  input  logic       i_set_bank,
  input  logic       i_row_done,
  output logic [1:0] o_ready,
  output logic       o_rd_bank,
  output logic       o_band_valid,
  output logic       o_underrun
`ifdef ETC_BAND_SCHED_STATS_EN
  ,
  output logic [7:0] o_underrun_cnt
`endif
);

  logic [1:0] r_ready, w_ready_nxt;
  logic [1:0] r_row_cnt, w_row_cnt_nxt;
  logic       r_rd_bank, w_rd_bank_nxt;
  logic       r_band_valid, w_band_valid_nxt;
  logic       r_underrun, w_underrun_nxt;
  logic       w_underrun_evt;

  // Restart overrides line events; a band-complete set beats a same-cycle release.
  always_comb begin
    w_ready_nxt    = r_ready;
    w_row_cnt_nxt  = r_row_cnt;
    w_rd_bank_nxt  = r_rd_bank;
    w_underrun_nxt = r_underrun;
    w_underrun_evt = 1'b0;
    if (i_init) begin
      w_ready_nxt    = 2'b00;
      w_row_cnt_nxt  = 2'd0;
      w_rd_bank_nxt  = 1'b0;
      w_underrun_nxt = 1'b0;
    end else begin
      if (i_row_done) begin
        w_underrun_evt = ~r_band_valid;
        w_underrun_nxt = r_underrun | ~r_band_valid;
        w_row_cnt_nxt  = r_row_cnt + 2'd1;
        if (r_row_cnt == 2'd3) begin
          w_ready_nxt[r_rd_bank] = 1'b0;
          w_rd_bank_nxt          = ~r_rd_bank;
        end
      end
      if (i_set) begin
        w_ready_nxt[i_set_bank] = 1'b1;
      end
    end
    w_band_valid_nxt = w_ready_nxt[w_rd_bank_nxt];
  end

  always_ff @(posedge sclk or posedge srst) begin
    if (srst) begin
      r_ready      <= 2'b00;
      r_row_cnt    <= 2'd0;
      r_rd_bank    <= 1'b0;
      r_band_valid <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_ready      <= w_ready_nxt;
      r_row_cnt    <= w_row_cnt_nxt;
      r_rd_bank    <= w_rd_bank_nxt;
      r_band_valid <= w_band_valid_nxt;
      r_underrun   <= w_underrun_nxt;
    end
  end

`ifdef ETC_BAND_SCHED_STATS_EN
  logic [7:0] r_underrun_cnt;

  always_ff @(posedge sclk or posedge srst) begin
    if (srst) begin
      r_underrun_cnt <= 8'd0;
    end else if (w_underrun_evt && (r_underrun_cnt != 8'hFF)) begin
      r_underrun_cnt <= r_underrun_cnt + 8'd1;
    end
  end

  assign o_underrun_cnt = r_underrun_cnt;
`else
  logic w_unused_evt;
  assign w_unused_evt = w_underrun_evt;
`endif

  assign o_ready      = r_ready;
  assign o_rd_bank    = r_rd_bank;
  assign o_band_valid = r_band_valid;
  assign o_underrun   = r_underrun;

endmodule

// File: rtl/etc_band_sched.sv
// Sequences ETC2 block decode requests into a two-bank band buffer ahead of the TFT scan.
// ETC_BAND_SCHED_STATS_EN adds blk_cnt and underrun_cnt outputs.
module etc_band_sched
  import etc_sched_pkg::*;
#(
  parameter int unsigned H_BLOCKS = H_BLOCKS_DEF,
  parameter int unsigned V_BLOCKS = V_BLOCKS_DEF,
  parameter int unsigned BX_W     = 7,
  parameter int unsigned BY_W     = 7
) (
  input  logic            sclk,
  input  logic            srst,
  input  logic            frame_start,
  input  logic            row_done,
  output logic            dec_req,
  input  logic            dec_ack,
  input  logic            dec_done,
  output logic [BX_W-1:0] dec_bx,
  output logic [BY_W-1:0] dec_by,
  output logic            dec_bank,
  output logic            rd_bank,
  output logic            band_valid,
  output logic            underrun,
  output logic            busy
`ifdef ETC_BAND_SCHED_STATS_EN
  ,
  output logic [15:0]     blk_cnt,
  output logic [7:0]      underrun_cnt
`endif
);

  sched_state_e    r_state, w_state_nxt;
  logic [BX_W-1:0] r_bx, w_bx_nxt;
  logic [BY_W-1:0] r_by, w_by_nxt;
  logic            r_dec_bank, w_bank_nxt;
  logic            r_pend, w_pend_nxt;
  logic            r_dec_req, r_busy;
  logic            w_init, w_set;
  logic [1:0]      w_ready;

  // Next-state: an accepted decode is always allowed to finish before a restart.
  always_comb begin
    w_state_nxt = r_state;
    w_bx_nxt    = r_bx;
    w_by_nxt    = r_by;
    w_bank_nxt  = r_dec_bank;
    w_pend_nxt  = r_pend;
    w_init      = 1'b0;
    w_set       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (frame_start) begin
          w_init      = 1'b1;
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (dec_ack) begin
          w_state_nxt = ST_WAIT;
          w_pend_nxt  = frame_start;
        end else if (frame_start) begin
          // One HOLD cycle drops dec_req; bank 0 is free after init so REQ follows.
          w_init      = 1'b1;
          w_state_nxt = ST_HOLD;
        end
      end
      ST_WAIT: begin
        if (frame_start) begin
          w_pend_nxt = 1'b1;
        end
        if (dec_done) begin
          if (r_pend || frame_start) begin
            w_init      = 1'b1;
            w_state_nxt = ST_REQ;
          end else if (r_bx != BX_W'(H_BLOCKS - 1)) begin
            w_bx_nxt    = r_bx + BX_W'(1);
            w_state_nxt = ST_REQ;
          end else begin
            w_set      = 1'b1;
            w_bx_nxt   = '0;
            w_bank_nxt = ~r_dec_bank;
            if (r_by == BY_W'(V_BLOCKS - 1)) begin
              w_state_nxt = ST_IDLE;
            end else begin
              w_by_nxt    = r_by + BY_W'(1);
              w_state_nxt = ST_HOLD;
            end
          end
        end
      end
      ST_HOLD: begin
        if (frame_start) begin
          w_init      = 1'b1;
          w_state_nxt = ST_REQ;
        end else if (!w_ready[r_dec_bank]) begin
          w_state_nxt = ST_REQ;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_init) begin
      w_bx_nxt   = '0;
      w_by_nxt   = '0;
      w_bank_nxt = 1'b0;
      w_pend_nxt = 1'b0;
    end
  end

  always_ff @(posedge sclk or posedge srst) begin
    if (srst) begin
      r_state    <= ST_IDLE;
      r_bx       <= '0;
      r_by       <= '0;
      r_dec_bank <= 1'b0;
      r_pend     <= 1'b0;
      r_dec_req  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_bx       <= w_bx_nxt;
      r_by       <= w_by_nxt;
      r_dec_bank <= w_bank_nxt;
      r_pend     <= w_pend_nxt;
      r_dec_req  <= (w_state_nxt == ST_REQ);
      r_busy     <= (w_state_nxt != ST_IDLE);
    end
  end

  etc_band_tracker u_tracker (
    .sclk           (sclk),
    .srst           (srst),
    .i_init         (w_init),
    .i_set          (w_set),
    .i_set_bank     (r_dec_bank),
    .i_row_done     (row_done),
    .o_ready        (w_ready),
    .o_rd_bank      (rd_bank),
    .o_band_valid   (band_valid),
    .o_underrun     (underrun)
`ifdef ETC_BAND_SCHED_STATS_EN
    ,
    .o_underrun_cnt (underrun_cnt)
`endif
  );

`ifdef ETC_BAND_SCHED_STATS_EN
  logic [15:0] r_blk_cnt;

  // Discarded completions during a restart carry w_init and are not counted.
  always_ff @(posedge sclk or posedge srst) begin
    if (srst) begin
      r_blk_cnt <= 16'd0;
    end else if (w_init) begin
      r_blk_cnt <= 16'd0;
    end else if ((r_state == ST_WAIT) && dec_done) begin
      r_blk_cnt <= r_blk_cnt + 16'd1;
    end
  end

  assign blk_cnt = r_blk_cnt;
`endif

  assign dec_req  = r_dec_req;
  assign dec_bx   = r_bx;
  assign dec_by   = r_by;
  assign dec_bank = r_dec_bank;
  assign busy     = r_busy;

endmodule

// File: tb/tb_etc_band_sched.sv
// Scoreboard bench for etc_band_sched with a 4x3-block frame.
module tb_etc_band_sched;

  localparam int unsigned H   = 4;
  localparam int unsigned V   = 3;
  localparam int unsigned BXW = 2;
  localparam int unsigned BYW = 2;

  logic           sclk;
  logic           srst;
  logic           frame_start;
  logic           row_done;
  logic           dec_req;
  logic           dec_ack;
  logic           dec_done;
  logic [BXW-1:0] dec_bx;
  logic [BYW-1:0] dec_by;
  logic           dec_bank;
  logic           rd_bank;
  logic           band_valid;
  logic           underrun;
  logic           busy;
`ifdef ETC_BAND_SCHED_STATS_EN
  logic [15:0]    blk_cnt;
  logic [7:0]     underrun_cnt;
`endif

  typedef struct packed {
    logic [BXW-1:0] bx;
    logic [BYW-1:0] by;
    logic           bank;
  } req_t;

  req_t sb_q[$];
  int   n_vec;
  int   n_err;

  etc_band_sched #(
    .H_BLOCKS (H),
    .V_BLOCKS (V),
    .BX_W     (BXW),
    .BY_W     (BYW)
  ) dut (
    .sclk         (sclk),
    .srst         (srst),
    .frame_start  (frame_start),
    .row_done     (row_done),
    .dec_req      (dec_req),
    .dec_ack      (dec_ack),
    .dec_done     (dec_done),
    .dec_bx       (dec_bx),
    .dec_by       (dec_by),
    .dec_bank     (dec_bank),
    .rd_bank      (rd_bank),
    .band_valid   (band_valid),
    .underrun     (underrun),
    .busy         (busy)
`ifdef ETC_BAND_SCHED_STATS_EN
    ,
    .blk_cnt      (blk_cnt),
    .underrun_cnt (underrun_cnt)
`endif
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge sclk);
    #1;
  endtask

  task automatic push_band(input int by, input logic bank);
    req_t e;
    for (int i = 0; i < int'(H); i++) begin
      e.bx   = BXW'(i);
      e.by   = BYW'(by);
      e.bank = bank;
      sb_q.push_back(e);
    end
  endtask

  task automatic row_pulse();
    row_done = 1'b1;
    step();
    row_done = 1'b0;
  endtask

  // Wait for a request, compare it to the scoreboard head, then acknowledge it.
  task automatic accept();
    req_t e;
    int   n;
    n = 0;
    while ((dec_req !== 1'b1) && (n < 50)) begin
      step();
      n++;
    end
    check("req_seen", 32'(dec_req), 32'd1);
    check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check("req_bx", 32'(dec_bx), 32'(e.bx));
      check("req_by", 32'(dec_by), 32'(e.by));
      check("req_bank", 32'(dec_bank), 32'(e.bank));
    end
    dec_ack = 1'b1;
    step();
    dec_ack = 1'b0;
    check("req_drop", 32'(dec_req), 32'd0);
  endtask

  task automatic serve(input logic row_at_done);
    accept();
    step();
    dec_done = 1'b1;
    row_done = row_at_done;
    step();
    dec_done = 1'b0;
    row_done = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec       = 0;
    n_err       = 0;
    srst        = 1'b1;
    frame_start = 1'b0;
    row_done    = 1'b0;
    dec_ack     = 1'b0;
    dec_done    = 1'b0;
    step();
    step();
    check("rst_dec_req", 32'(dec_req), 32'd0);
    check("rst_dec_bx", 32'(dec_bx), 32'd0);
    check("rst_dec_by", 32'(dec_by), 32'd0);
    check("rst_dec_bank", 32'(dec_bank), 32'd0);
    check("rst_rd_bank", 32'(rd_bank), 32'd0);
    check("rst_band_valid", 32'(band_valid), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    srst = 1'b0;
    step();
    check("idle_busy", 32'(busy), 32'd0);

    // Frame in order: band0 into bank0, band1 into bank1, then stall on bank0.
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check("fs_req", 32'(dec_req), 32'd1);
    check("fs_busy", 32'(busy), 32'd1);
    push_band(0, 1'b0);
    push_band(1, 1'b1);
    serve(1'b0);
    check("next_req_1cyc", 32'(dec_req), 32'd1);
    check("next_bx", 32'(dec_bx), 32'd1);
    for (int i = 1; i < int'(H); i++) serve(1'b0);
    check("band0_ready", 32'(band_valid), 32'd1);
    check("hold_enter_req", 32'(dec_req), 32'd0);
    check("hold_by", 32'(dec_by), 32'd1);
    check("hold_bank", 32'(dec_bank), 32'd1);
    for (int i = 0; i < int'(H); i++) serve(1'b0);
    repeat (20) step();
    check("stall_req", 32'(dec_req), 32'd0);
    check("stall_busy", 32'(busy), 32'd1);
    check("stall_by", 32'(dec_by), 32'd2);
    check("stall_bank", 32'(dec_bank), 32'd0);
    check("stall_underrun", 32'(underrun), 32'd0);

    // Four lines release bank0; the band2 request follows one cycle later.
    for (int i = 0; i < 3; i++) begin
      row_pulse();
      check("rows_rd_bank", 32'(rd_bank), 32'd0);
      step();
    end
    row_pulse();
    check("release_rd_bank", 32'(rd_bank), 32'd1);
    check("release_valid", 32'(band_valid), 32'd1);
    check("release_req_early", 32'(dec_req), 32'd0);
    check("release_underrun", 32'(underrun), 32'd0);
    step();
    check("release_req", 32'(dec_req), 32'd1);
    push_band(2, 1'b0);
    for (int i = 0; i < int'(H); i++) serve(1'b0);
    check("frame_end_busy", 32'(busy), 32'd0);
    check("frame_end_req", 32'(dec_req), 32'd0);

    // Underrun on a line read before band0 exists; cleared by the next frame_start.
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check("fs2_rd_bank", 32'(rd_bank), 32'd0);
    check("fs2_valid", 32'(band_valid), 32'd0);
    row_pulse();
    check("underrun_set", 32'(underrun), 32'd1);
    step();
    sb_q.delete();
    push_band(0, 1'b0);
    serve(1'b0);
    check("underrun_sticky", 32'(underrun), 32'd1);
    check("req_pending", 32'(dec_req), 32'd1);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check("fs_req_drop", 32'(dec_req), 32'd0);
    check("underrun_clr", 32'(underrun), 32'd0);

    // frame_start while (2,1) is being decoded waits for its completion.
    sb_q.delete();
    push_band(0, 1'b0);
    push_band(1, 1'b1);
    for (int i = 0; i < int'(H) + 2; i++) serve(1'b0);
    accept();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check("wait_fs_req", 32'(dec_req), 32'd0);
    repeat (5) step();
    check("wait_fs_req_hold", 32'(dec_req), 32'd0);
    check("wait_fs_busy", 32'(busy), 32'd1);
    dec_done = 1'b1;
    step();
    dec_done = 1'b0;
    check("restart_req", 32'(dec_req), 32'd1);
    check("restart_bx", 32'(dec_bx), 32'd0);
    check("restart_by", 32'(dec_by), 32'd0);
    check("restart_bank", 32'(dec_bank), 32'd0);
    check("restart_valid", 32'(band_valid), 32'd0);

    // Band1 completion and bank1 release in the same cycle: the set wins.
    sb_q.delete();
    push_band(0, 1'b0);
    for (int i = 0; i < int'(H); i++) serve(1'b0);
    for (int i = 0; i < 3; i++) begin
      row_pulse();
      step();
    end
    row_pulse();
    check("sw_rd_bank1", 32'(rd_bank), 32'd1);
    check("sw_valid0", 32'(band_valid), 32'd0);
    check("sw_underrun0", 32'(underrun), 32'd0);
    push_band(1, 1'b1);
    for (int i = 0; i < int'(H) - 1; i++) serve(1'b0);
    for (int i = 0; i < 3; i++) begin
      row_pulse();
      step();
    end
    check("sw_underrun1", 32'(underrun), 32'd1);
    serve(1'b1);
    check("sw_rd_bank0", 32'(rd_bank), 32'd0);
    check("sw_valid_bank0", 32'(band_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      row_pulse();
      step();
    end
    row_pulse();
    check("sw_rd_bank_back", 32'(rd_bank), 32'd1);
    check("set_wins", 32'(band_valid), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/etc_band_sched.md
# etc_band_sched

Scheduler that sequences the ETC2 block decoder ahead of the TFT raster scan. Issues one 4x4-block decode request at a time, left to right and top to bottom, into a two-bank band buffer; each bank holds one band, i.e. one row of blocks covering 4 pixel lines. Tracks which bank the display is reading and flags display underrun. Sits between the TFT timing generator (`tft_color` path) and the decoder/band-buffer write port.

## Interface
- `H_BLOCKS`, default 120 — blocks per band (480 px / 4).
- `V_BLOCKS`, default 68 — bands per frame (272 px / 4).
- `BX_W`, default 7 — width of block column index, must hold H_BLOCKS-1.
- `BY_W`, default 7 — width of block row index, must hold V_BLOCKS-1.
- `sclk  in  1` — system clock. One clock domain for the whole block.
- `srst  in  1` — reset. Asynchronous and active-high.
- `frame_start  in  1` — 1-cycle pulse from TFT timing at frame start.
- `row_done  in  1` — 1-cycle pulse when one active display line has been read out.
- `dec_req  out  1` — decode request.
- `dec_ack  in  1` — decoder accepts the request.
- `dec_done  in  1` — 1-cycle pulse; accepted block is fully written.
- `dec_bx  out  BX_W` — block column of the request.
- `dec_by  out  BY_W` — block row of the request.
- `dec_bank  out  1` — band-buffer bank the decoder writes.
- `rd_bank  out  1` — bank the display reads.
- `band_valid  out  1` — the `rd_bank` bank holds a complete band.
- `underrun  out  1` — sticky error flag. Cleared at frame start.
- `busy  out  1` — high in every state except IDLE.

## Operation
- FSM states: IDLE, REQ, WAIT, HOLD. `ready[1:0]` holds one complete-band bit per bank.
- IDLE → REQ on `frame_start`. On that transition: bx=0, by=0, dec_bank=0, rd_bank=0, ready=00, row_cnt=0, underrun=0.
- REQ: `dec_req`=1. `dec_bx`/`dec_by`/`dec_bank` stay stable until `dec_ack`. On `dec_ack` → WAIT and `dec_req` drops.
- WAIT, on `dec_done`:
  - If bx<H_BLOCKS-1: bx++ and → REQ.
  - If bx=H_BLOCKS-1: set `ready[dec_bank]`, bx=0, toggle dec_bank.
    - If by=V_BLOCKS-1 → IDLE.
    - Otherwise by++ → HOLD.
- HOLD → REQ when `ready[dec_bank]`=0. A bank is never overwritten while the display still holds it.
- Display side:
  - row_cnt is 2 bits and increments on `row_done`.
  - On `row_done` with row_cnt=3: clear `ready[rd_bank]`, toggle rd_bank, row_cnt wraps to 0.
- `band_valid` = `ready[rd_bank]`.
- `underrun` sets when `row_done` arrives while `band_valid`=0.
- `dec_ack` and `dec_done` are ignored outside REQ and WAIT respectively.
- `frame_start` while not IDLE:
  - REQ: drop `dec_req` next cycle and restart as from IDLE.
  - WAIT: set restart_pending. Wait for `dec_done`, discard its band bookkeeping, then restart. Never abandon an accepted decode.
  - HOLD: restart immediately.
- Simultaneous events:
  - `frame_start` beats `row_done`.
  - Set and clear of the same `ready` bit in one cycle: set wins.

## Timing
- Reset value of every output: `dec_req`=0, `dec_bx`=0, `dec_by`=0, `dec_bank`=0, `rd_bank`=0, `band_valid`=0, `underrun`=0, `busy`=0. FSM resets to IDLE.
- All outputs are registered.
- `frame_start` at cycle t → `dec_req`=1 at t+1.
- `dec_ack` at t → `dec_req`=0 at t+1.
- `dec_done` at t → next `dec_req`=1 at t+1 within a band. At band end, `ready` is set at t+1.
- `row_done` on the 4th line at t → `rd_bank` toggles and `band_valid` updates at t+1.
- Restart from WAIT: `dec_done` at t → `dec_req`=1 with bx=by=0 at t+1.

## Configuration
- `ETC_BAND_SCHED_STATS_EN` defined:
  - Adds output `blk_cnt` [15:0]: blocks completed this frame, cleared at `frame_start`.
  - Adds output `underrun_cnt` [7:0]: saturates at 255, cleared only by `srst`.
- Undefined: neither port nor counter exists. All other behaviour is identical.

## Structure
- Package `etc_sched_pkg`: FSM state enum and the default H_BLOCKS/V_BLOCKS localparams for the 480x272 panel.
- Sub-module `etc_band_tracker` holds the display-side logic: row_cnt, rd_bank, `ready` clear, `underrun`. It takes set strobes from the FSM.

## Test plan
All scenarios use H_BLOCKS=4, V_BLOCKS=3.
- Reset then one `frame_start`, decoder acks and completes every request after 2 cycles:
  - Request order is (0,0)…(3,0) bank0, then (0,1)… bank1.
  - HOLD is entered before by=2 until the display frees bank0.
- No `row_done` after band0 and band1 complete → FSM stays in HOLD, `dec_req`=0, `busy`=1 indefinitely.
- 4 `row_done` pulses with band0 ready → `rd_bank` 0→1 and `ready[0]` cleared; `dec_req` for (0,2) bank0 follows 1 cycle later.
- `row_done` before band0 completes → `underrun`=1 and stays 1 until the next `frame_start`.
- `frame_start` in WAIT at (2,1) → no new `dec_req` until `dec_done`; at the next cycle `dec_req`=1 with (0,0) bank0.
- Same-cycle `dec_done` (band end, bank1) and 4th `row_done` releasing bank1 → `ready[1]`=1 afterwards (set wins).
